// File: rtl/vpu_pkg.sv
// Shared definitions for the SIMD vector pipeline: opcodes, field positions,
// width codes and the canonical NOP word. The decode stage and the ALU both
// import this package.
package vpu_pkg;

  localparam int VPU_DATA_W  = 64;
  localparam int VPU_NREGS   = 32;
  localparam int VPU_INSTR_W = 32;

  // Instruction bit 0 is the MSB, so field [a:b] in instruction numbering
  // lives at [31-a:31-b] in the packed vector.
  localparam int TYPE_HI = 31;
  localparam int TYPE_LO = 26;
  localparam int RD_HI   = 25;
  localparam int RD_LO   = 21;
  localparam int RA_HI   = 20;
  localparam int RA_LO   = 16;
  localparam int RB_HI   = 15;
  localparam int RB_LO   = 11;
  localparam int WW_HI   = 7;
  localparam int WW_LO   = 6;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  // Instruction type codes
  localparam logic [5:0] OP_R_ALU = 6'b101010;
  localparam logic [5:0] OP_LOAD  = 6'b100000;
  localparam logic [5:0] OP_STORE = 6'b100001;
  localparam logic [5:0] OP_BEZ   = 6'b100010;
  localparam logic [5:0] OP_BNEZ  = 6'b100011;
  localparam logic [5:0] OP_NOP   = 6'b111100;

  // R_ALU function codes
  localparam logic [5:0] FN_VNOP = 6'b000000;
  localparam logic [5:0] FN_VAND = 6'b000001;
  localparam logic [5:0] FN_VOR  = 6'b000010;
  localparam logic [5:0] FN_VXOR = 6'b000011;
  localparam logic [5:0] FN_VNOT = 6'b000100;
  localparam logic [5:0] FN_VMOV = 6'b000101;
  localparam logic [5:0] FN_VADD = 6'b000110;
  localparam logic [5:0] FN_VSUB = 6'b000111;

  // Element width codes (WW field)
  localparam logic [1:0] WW_8  = 2'b00;
  localparam logic [1:0] WW_16 = 2'b01;
  localparam logic [1:0] WW_32 = 2'b10;
  localparam logic [1:0] WW_64 = 2'b11;

  localparam logic [VPU_INSTR_W-1:0] NOP_INSTR = {OP_NOP, 26'd0};

  typedef enum logic [2:0] {
    K_NOP,
    K_R_ALU,
    K_LOAD,
    K_STORE,
    K_BEZ,
    K_BNEZ
  } instr_kind_e;

  // Unknown type codes are treated exactly like NOP.
  function automatic instr_kind_e decode_kind(input logic [5:0] op);
    case (op)
      OP_R_ALU: return K_R_ALU;
      OP_LOAD:  return K_LOAD;
      OP_STORE: return K_STORE;
      OP_BEZ:   return K_BEZ;
      OP_BNEZ:  return K_BNEZ;
      default:  return K_NOP;
    endcase
  endfunction

endpackage

// File: rtl/vreg_file.sv
// Vector register file: NREGS x DATA_W, three combinational read ports
// (A, B, D) and one write port. A write in the same cycle as a read of the
// same register is forwarded to the read port.
module vreg_file
  import vpu_pkg::*;
#(
  parameter int DATA_W = VPU_DATA_W,
  parameter int NREGS  = VPU_NREGS,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  input  logic [AW-1:0]     rd_addr_d,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] rd_data_d
);

  logic [DATA_W-1:0] mem [NREGS];

  // Storage array; register 0 is writable like any other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Write-first read ports so a consumer can issue in its producer's WB cycle.
  always_comb begin
    rd_data_a = mem[rd_addr_a];
    rd_data_b = mem[rd_addr_b];
    rd_data_d = mem[rd_addr_d];
    if (wr_en && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
    if (wr_en && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
    if (wr_en && (wr_addr == rd_addr_d)) rd_data_d = wr_data;
  end

endmodule

// File: rtl/vector_decode_stage.sv
// Decode stage of the SIMD pipeline: register file, RAW scoreboard, branch
// resolution and the ID/EX pipeline register.
module vector_decode_stage
  import vpu_pkg::*;
#(
  parameter int DATA_W = VPU_DATA_W,
  parameter int NREGS  = VPU_NREGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       IF_ID_Instr,
  input  logic              IF_ID_Valid,
  input  logic              WB_WrEn,
  input  logic [4:0]        WB_WrAddr,
  input  logic [DATA_W-1:0] WB_WrData,
  output logic [31:0]       ID_EX_Instr,
  output logic [DATA_W-1:0] ID_EX_A,
  output logic [DATA_W-1:0] ID_EX_B,
  output logic [DATA_W-1:0] ID_EX_D,
  output logic              ID_EX_Valid,
  output logic              Stall,
  output logic              Branch_Taken,
  output logic [31:0]       Branch_Target
);

  logic [5:0]  f_type;
  logic [4:0]  f_rd;
  logic [4:0]  f_ra;
  logic [4:0]  f_rb;
  logic [5:0]  f_func;
  logic [15:0] f_imm;
  instr_kind_e kind;

  assign f_type = IF_ID_Instr[TYPE_HI:TYPE_LO];
  assign f_rd   = IF_ID_Instr[RD_HI:RD_LO];
  assign f_ra   = IF_ID_Instr[RA_HI:RA_LO];
  assign f_rb   = IF_ID_Instr[RB_HI:RB_LO];
  assign f_func = IF_ID_Instr[FUNC_HI:FUNC_LO];
  assign f_imm  = IF_ID_Instr[IMM_HI:IMM_LO];
  assign kind   = decode_kind(f_type);

  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_b;
  logic [DATA_W-1:0] val_d;

  vreg_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_vreg_file (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (WB_WrEn),
    .wr_addr   (WB_WrAddr),
    .wr_data   (WB_WrData),
    .rd_addr_a (f_ra),
    .rd_addr_b (f_rb),
    .rd_addr_d (f_rd),
    .rd_data_a (val_a),
    .rd_data_b (val_b),
    .rd_data_d (val_d)
  );

  logic             use_ra;
  logic             use_rb;
  logic             use_rd;
  logic             writer;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] busy_live;
  logic [NREGS-1:0] set_mask;
  logic             squash;
  logic             src_busy;
  logic             accept;
  logic             issue;
  logic             rd_zero;
  logic             br_taken;

  // Which register specifiers this instruction reads, and whether it writes rD.
  always_comb begin
    use_ra = 1'b0;
    use_rb = 1'b0;
    use_rd = 1'b0;
    writer = 1'b0;
    case (kind)
      K_R_ALU: begin
        use_ra = 1'b1;
        use_rb = (f_func != FN_VNOT) && (f_func != FN_VMOV);
        writer = (f_func != FN_VNOP);
      end
      K_LOAD:  writer = 1'b1;
      K_STORE: use_rd = 1'b1;
      K_BEZ:   use_rd = 1'b1;
      K_BNEZ:  use_rd = 1'b1;
      default: ;
    endcase
  end

  // A write-back this cycle releases its register before the hazard check,
  // which lets the consumer issue in the producer's WB cycle.
  always_comb begin
    wb_clr = '0;
    if (WB_WrEn) wb_clr[WB_WrAddr] = 1'b1;
  end

  assign busy_live = busy & ~wb_clr;
  assign src_busy  = (use_ra & busy_live[f_ra]) |
                     (use_rb & busy_live[f_rb]) |
                     (use_rd & busy_live[f_rd]);

  assign Stall    = IF_ID_Valid & ~squash & src_busy;
  assign accept   = IF_ID_Valid & ~squash & ~src_busy;
  assign issue    = accept & ((kind == K_R_ALU) | (kind == K_LOAD) | (kind == K_STORE));
  assign rd_zero  = (val_d == '0);
  assign br_taken = accept & (((kind == K_BEZ) & rd_zero) | ((kind == K_BNEZ) & ~rd_zero));

  // Destination reservation for an issuing writer.
  always_comb begin
    set_mask = '0;
    if (issue && writer) set_mask[f_rd] = 1'b1;
  end

  // Scoreboard: set is applied after the WB clear so a same-cycle set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_live | set_mask;
  end

  // Squash flag drops the wrong-path fetch that follows a taken branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) squash <= 1'b0;
    else       squash <= br_taken;
  end

  // ID/EX register: real instruction with operands, or a zeroed NOP bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ID_EX_Instr <= NOP_INSTR;
      ID_EX_A     <= '0;
      ID_EX_B     <= '0;
      ID_EX_D     <= '0;
      ID_EX_Valid <= 1'b0;
    end else if (issue) begin
      ID_EX_Instr <= IF_ID_Instr;
      ID_EX_A     <= val_a;
      ID_EX_B     <= val_b;
      ID_EX_D     <= val_d;
      ID_EX_Valid <= 1'b1;
    end else begin
      ID_EX_Instr <= NOP_INSTR;
      ID_EX_A     <= '0;
      ID_EX_B     <= '0;
      ID_EX_D     <= '0;
      ID_EX_Valid <= 1'b0;
    end
  end

  // Branch redirect: one-cycle pulse, target held until the next taken branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Branch_Taken  <= 1'b0;
      Branch_Target <= '0;
    end else begin
      Branch_Taken <= br_taken;
      if (br_taken) Branch_Target <= {16'd0, f_imm};
    end
  end

endmodule

// File: tb/tb_vector_decode_stage.sv
// Bench for vector_decode_stage: directed scenarios followed by a randomized
// run checked against a register/scoreboard reference model.
module tb_vector_decode_stage;
  import vpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [31:0] id_ex_instr;
  logic [63:0] id_ex_a;
  logic [63:0] id_ex_b;
  logic [63:0] id_ex_d;
  logic        id_ex_valid;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP_WORD = 32'hF000_0000;

  vector_decode_stage dut (
    .clk           (clk),
    .reset         (reset),
    .IF_ID_Instr   (if_id_instr),
    .IF_ID_Valid   (if_id_valid),
    .WB_WrEn       (wb_en),
    .WB_WrAddr     (wb_addr),
    .WB_WrData     (wb_data),
    .ID_EX_Instr   (id_ex_instr),
    .ID_EX_A       (id_ex_a),
    .ID_EX_B       (id_ex_b),
    .ID_EX_D       (id_ex_d),
    .ID_EX_Valid   (id_ex_valid),
    .Stall         (stall),
    .Branch_Taken  (br_taken),
    .Branch_Target (br_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_r(input logic [5:0] t, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb,
                                       input logic [5:0] fn);
    return {t, rd, ra, rb, 3'b000, 2'b11, fn};
  endfunction

  function automatic logic [31:0] mk_br(input logic [5:0] t, input logic [4:0] rd,
                                        input logic [15:0] imm);
    return {t, rd, 5'd0, imm};
  endfunction

  // Registers an instruction reads, straight from the ISA source rules.
  function automatic logic [31:0] src_mask(input logic [31:0] ins);
    logic [31:0] m;
    m = '0;
    case (ins[31:26])
      6'b101010: begin
        m[ins[20:16]] = 1'b1;
        if (ins[5:0] != FN_VNOT && ins[5:0] != FN_VMOV) m[ins[15:11]] = 1'b1;
      end
      6'b100001, 6'b100010, 6'b100011: m[ins[25:21]] = 1'b1;
      default: ;
    endcase
    return m;
  endfunction

  function automatic bit goes_to_ex(input logic [31:0] ins);
    return ins[31:26] == 6'b101010 || ins[31:26] == 6'b100000 || ins[31:26] == 6'b100001;
  endfunction

  function automatic bit writes_rd(input logic [31:0] ins);
    return ins[31:26] == 6'b100000 || (ins[31:26] == 6'b101010 && ins[5:0] != 6'b000000);
  endfunction

  task automatic idle_inputs();
    if_id_instr = NOP_WORD;
    if_id_valid = 1'b0;
    wb_en       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [63:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #2;
    checks++; if (id_ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", id_ex_valid); end
    checks++; if (id_ex_instr !== NOP_WORD) begin errors++; $display("FAIL reset_instr: got %h want %h", id_ex_instr, NOP_WORD); end
    checks++; if ({id_ex_a, id_ex_b, id_ex_d} !== 192'd0) begin errors++; $display("FAIL reset_operands: got %h %h %h want 0", id_ex_a, id_ex_b, id_ex_d); end
    checks++; if (br_taken !== 1'b0 || br_target !== 32'd0) begin errors++; $display("FAIL reset_branch: got %0b %h want 0 0", br_taken, br_target); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_issue();
    apply_reset();
    wb_write(5'd1, 64'd5);
    wb_write(5'd2, 64'd7);
    if_id_instr = mk_r(OP_R_ALU, 5'd3, 5'd1, 5'd2, FN_VADD);
    if_id_valid = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL issue_stall: got %0b want 0", stall); end
    tick();
    checks++; if (id_ex_valid !== 1'b1) begin errors++; $display("FAIL issue_valid: got %0b want 1", id_ex_valid); end
    checks++; if (id_ex_a !== 64'd5 || id_ex_b !== 64'd7) begin errors++; $display("FAIL issue_operands: got A=%0h B=%0h want A=5 B=7", id_ex_a, id_ex_b); end
    checks++; if (id_ex_instr !== mk_r(OP_R_ALU, 5'd3, 5'd1, 5'd2, FN_VADD)) begin errors++; $display("FAIL issue_instr: got %h", id_ex_instr); end
    idle_inputs();
  endtask

  task automatic test_raw();
    apply_reset();
    if_id_instr = mk_r(OP_LOAD, 5'd4, 5'd0, 5'd0, 6'd0);
    if_id_valid = 1'b1;
    tick();
    checks++; if (id_ex_valid !== 1'b1) begin errors++; $display("FAIL raw_load_issue: got %0b want 1", id_ex_valid); end
    if_id_instr = mk_r(OP_R_ALU, 5'd5, 5'd4, 5'd4, FN_VADD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall[%0d]: got %0b want 1", i, stall); end
      tick();
      checks++; if (id_ex_valid !== 1'b0 || id_ex_instr !== NOP_WORD) begin errors++; $display("FAIL raw_bubble[%0d]: got valid=%0b instr=%h want 0 %h", i, id_ex_valid, id_ex_instr, NOP_WORD); end
    end
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 64'd9;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_wb_release: got %0b want 0", stall); end
    tick();
    checks++; if (id_ex_valid !== 1'b1 || id_ex_a !== 64'd9 || id_ex_b !== 64'd9) begin errors++; $display("FAIL raw_bypass_issue: got valid=%0b A=%0h B=%0h want 1 9 9", id_ex_valid, id_ex_a, id_ex_b); end
    idle_inputs();
  endtask

  task automatic test_bypass();
    apply_reset();
    if_id_instr = mk_r(OP_R_ALU, 5'd8, 5'd6, 5'd6, FN_VOR);
    if_id_valid = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 64'hAA;
    tick();
    checks++; if (id_ex_a !== 64'hAA || id_ex_b !== 64'hAA) begin errors++; $display("FAIL bypass_operands: got A=%0h B=%0h want aa aa", id_ex_a, id_ex_b); end
    idle_inputs();
  endtask

  task automatic test_branch();
    apply_reset();
    if_id_instr = mk_br(OP_BEZ, 5'd7, 16'h0040);
    if_id_valid = 1'b1;
    tick();
    checks++; if (br_taken !== 1'b1 || br_target !== 32'h40) begin errors++; $display("FAIL bez_taken: got %0b %h want 1 00000040", br_taken, br_target); end
    checks++; if (id_ex_valid !== 1'b0) begin errors++; $display("FAIL bez_not_to_ex: got %0b want 0", id_ex_valid); end
    if_id_instr = mk_r(OP_R_ALU, 5'd1, 5'd2, 5'd3, FN_VADD);
    tick();
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL bez_pulse_width: got %0b want 0", br_taken); end
    checks++; if (id_ex_valid !== 1'b0) begin errors++; $display("FAIL bez_squash: got %0b want 0", id_ex_valid); end
    if_id_instr = mk_r(OP_R_ALU, 5'd9, 5'd1, 5'd1, FN_VADD);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL squash_no_reserve: got %0b want 0", stall); end
    tick();
    checks++; if (id_ex_valid !== 1'b1) begin errors++; $display("FAIL after_squash_issue: got %0b want 1", id_ex_valid); end
    idle_inputs();
  endtask

  task automatic test_bnez();
    apply_reset();
    if_id_instr = mk_br(OP_BNEZ, 5'd7, 16'h0055);
    if_id_valid = 1'b1;
    tick();
    checks++; if (br_taken !== 1'b0 || id_ex_valid !== 1'b0) begin errors++; $display("FAIL bnez_not_taken: got taken=%0b valid=%0b want 0 0", br_taken, id_ex_valid); end
    if_id_instr = mk_r(OP_R_ALU, 5'd1, 5'd2, 5'd3, FN_VADD);
    tick();
    checks++; if (id_ex_valid !== 1'b1) begin errors++; $display("FAIL bnez_next_issue: got %0b want 1", id_ex_valid); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    if_id_instr = mk_r(OP_LOAD, 5'd4, 5'd0, 5'd0, 6'd0);
    if_id_valid = 1'b1;
    tick();
    if_id_instr = mk_r(OP_R_ALU, 5'd5, 5'd4, 5'd4, FN_VADD);
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midrst_pre_stall: got %0b want 1", stall); end
    reset = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_sb_clear: got %0b want 0", stall); end
    checks++; if (id_ex_valid !== 1'b0 || id_ex_instr !== NOP_WORD || br_taken !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got valid=%0b instr=%h taken=%0b", id_ex_valid, id_ex_instr, br_taken); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (id_ex_valid !== 1'b1 || id_ex_a !== 64'd0 || id_ex_b !== 64'd0) begin errors++; $display("FAIL midrst_fresh_issue: got valid=%0b A=%0h B=%0h want 1 0 0", id_ex_valid, id_ex_a, id_ex_b); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [63:0] regs [32];
    logic [31:0] busy;
    logic [4:0]  pend [$];
    bit          squash;
    bit          hold;
    logic [31:0] exp_target;
    logic [31:0] ins;
    logic [31:0] srcs;
    logic [31:0] clr;
    bit          exp_stall;
    bit          exp_valid;
    bit          exp_bt;
    logic [31:0] exp_instr;
    logic [63:0] ea, eb, ed;
    logic [63:0] va, vb, vd;
    logic [5:0]  t;
    logic [5:0]  fn;

    apply_reset();
    for (int i = 0; i < 32; i++) regs[i] = '0;
    busy = '0; squash = 0; hold = 0; exp_target = '0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold) begin
        case ($urandom_range(7, 0))
          0, 1, 2: t = OP_R_ALU;
          3:       t = OP_LOAD;
          4:       t = OP_STORE;
          5:       t = OP_BEZ;
          6:       t = OP_BNEZ;
          default: t = ($urandom_range(1, 0) == 0) ? OP_NOP : 6'b010101;
        endcase
        case ($urandom_range(6, 0))
          0: fn = FN_VNOP;
          1: fn = FN_VADD;
          2: fn = FN_VSUB;
          3: fn = FN_VAND;
          4: fn = FN_VOR;
          5: fn = FN_VNOT;
          default: fn = FN_VMOV;
        endcase
        if (t == OP_BEZ || t == OP_BNEZ)
          if_id_instr = mk_br(t, 5'($urandom_range(7, 0)), 16'($urandom));
        else
          if_id_instr = mk_r(t, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                             5'($urandom_range(7, 0)), fn);
        if_id_valid = ($urandom_range(7, 0) != 0);
      end
      if (pend.size() > 0 && $urandom_range(1, 0) == 1) begin
        wb_en = 1'b1;
        wb_addr = pend.pop_front();
        wb_data = ($urandom_range(3, 0) == 0) ? 64'd0 : {$urandom, $urandom};
      end else begin
        wb_en = 1'b0;
      end

      ins  = if_id_instr;
      va   = (wb_en && wb_addr == ins[20:16]) ? wb_data : regs[ins[20:16]];
      vb   = (wb_en && wb_addr == ins[15:11]) ? wb_data : regs[ins[15:11]];
      vd   = (wb_en && wb_addr == ins[25:21]) ? wb_data : regs[ins[25:21]];
      srcs = src_mask(ins);
      clr  = '0;
      if (wb_en) clr[wb_addr] = 1'b1;
      exp_stall = if_id_valid && !squash && ((srcs & busy & ~clr) != 0);

      @(negedge clk);
      checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d: got %0b want %0b", cyc, stall, exp_stall); end

      exp_valid = 0; exp_bt = 0; exp_instr = NOP_WORD; ea = '0; eb = '0; ed = '0;
      busy = busy & ~clr;
      if (wb_en) regs[wb_addr] = wb_data;
      if (if_id_valid && !squash && !exp_stall) begin
        if (goes_to_ex(ins)) begin
          exp_valid = 1; exp_instr = ins; ea = va; eb = vb; ed = vd;
          if (writes_rd(ins)) begin
            busy[ins[25:21]] = 1'b1;
            pend.push_back(ins[25:21]);
          end
        end else if ((ins[31:26] == 6'b100010 && vd == 0) || (ins[31:26] == 6'b100011 && vd != 0)) begin
          exp_bt = 1;
          exp_target = {16'd0, ins[15:0]};
        end
      end
      squash = exp_bt;
      hold = exp_stall;

      tick();
      checks++; if (id_ex_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d: got %0b want %0b", cyc, id_ex_valid, exp_valid); end
      checks++; if (id_ex_instr !== exp_instr) begin errors++; $display("FAIL rnd_instr cyc=%0d: got %h want %h", cyc, id_ex_instr, exp_instr); end
      checks++; if (id_ex_a !== ea || id_ex_b !== eb || id_ex_d !== ed) begin errors++; $display("FAIL rnd_operands cyc=%0d: got %h %h %h want %h %h %h", cyc, id_ex_a, id_ex_b, id_ex_d, ea, eb, ed); end
      checks++; if (br_taken !== exp_bt) begin errors++; $display("FAIL rnd_branch cyc=%0d: got %0b want %0b", cyc, br_taken, exp_bt); end
      if (exp_bt) begin
        checks++; if (br_target !== exp_target) begin errors++; $display("FAIL rnd_target cyc=%0d: got %h want %h", cyc, br_target, exp_target); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_issue();
    test_raw();
    test_bypass();
    test_branch();
    test_bnez();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_decode_stage.md
# vector_decode_stage

Instruction-decode stage of the 64-bit SIMD pipeline. It sits between the IF/ID register and the vector ALU and owns the 32 × 64-bit register file with its write-back port. It keeps a register scoreboard for RAW interlock and resolves BEZ/BNEZ branches. Each cycle it issues either one decoded instruction with operands, or a bubble, into the ID/EX register the ALU consumes.

## Interface
- DATA_W, 64, register/operand width
- NREGS, 32, register-file depth (5-bit specifiers)
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- IF_ID_Instr  in  32  instruction, bit 0 = MSB: [0:5] type, [6:10] rD, [11:15] rA, [16:20] rB, [24:25] WW, [26:31] func, [16:31] imm
- IF_ID_Valid  in  1  IF_ID_Instr holds a real instruction
- WB_WrEn  in  1  write-back strobe
- WB_WrAddr  in  5  write-back register
- WB_WrData  in  64  write-back data
- ID_EX_Instr  out  32  issued instruction; NOP type (6'b111100) when bubble
- ID_EX_A  out  64  rA contents
- ID_EX_B  out  64  rB contents
- ID_EX_D  out  64  rD contents (store data)
- ID_EX_Valid  out  1  ID/EX holds a real instruction
- Stall  out  1  combinational; IF holds PC and IF/ID this cycle
- Branch_Taken  out  1  registered one-cycle pulse
- Branch_Target  out  32  {16'b0, imm}, valid with Branch_Taken

## Operation
- Types: R_ALU 6'b101010, LOAD 6'b100000, STORE 6'b100001, BEZ 6'b100010, BNEZ 6'b100011, NOP 6'b111100. Any other type decodes as NOP.
- Writers: LOAD, and R_ALU with func ≠ VNOP (6'b000000). Sources per type:
  - R_ALU: rA, plus rB unless func is VNOT or VMOV.
  - STORE: rD.
  - BEZ/BNEZ: rD.
  - LOAD, NOP: none.
- Register file read: combinational. A same-cycle WB write to the read address bypasses WB_WrData. Register 0 is an ordinary register.
- Scoreboard: one busy bit per register.
  - Set on issue of a writer to rD.
  - Cleared on WB_WrEn to WB_WrAddr.
  - Same-cycle set and clear on one register: set wins.
- Stall = IF_ID_Valid & !squash & (any source busy and not cleared by WB this cycle).
  - While stalled, a bubble is issued: ID_EX_Valid=0, ID_EX_Instr=NOP, operands 0.
- Issue: when not stalled and not squashed, a valid R_ALU/LOAD/STORE is registered into ID/EX with ID_EX_Valid=1.
- Branches: resolved in ID, never sent to EX (bubble issued).
  - BEZ is taken when rD == 0; BNEZ is taken when rD ≠ 0.
  - Taken: Branch_Taken=1 next cycle, and the squash flag is set.
  - Squash discards the next IF_ID instruction (bubble issued, no scoreboard update), then clears.
- Reset:
  - Register file, scoreboard and squash cleared.
  - ID_EX_Instr=NOP, ID_EX_A/B/D=0, ID_EX_Valid=0.
  - Branch_Taken=0, Branch_Target=0.
  - Reset mid-stall drops the pending instruction; IF must refetch.

## Timing
- Issue latency: 1 cycle from IF_ID_Instr to ID/EX outputs.
- Register file and scoreboard update on the rising edge. WB data written at edge N is visible to reads in cycle N by bypass.
- Stall is combinational from IF_ID_Instr, the scoreboard and the WB inputs. It must settle within the cycle. It has no dependence on ID/EX outputs, so no loop exists.
- Back-to-back dependent instructions: the consumer stalls until the producer's WB cycle. It issues in that WB cycle using bypassed data.
- Branch_Taken is high for exactly one cycle, in the cycle after the branch sits in IF/ID unstalled.

## Structure
- Shared package `vpu_pkg`:
  - Type and func opcode constants.
  - WW width codes.
  - Instruction field bit-range localparams.
  - NOP instruction word.
  - Also imported by the ALU.
- Sub-module `vreg_file`: 32 × 64 registers, async reset, two plus one read ports (A, B, D), one write port, internal write-first bypass.
- Scoreboard, hazard logic, branch resolution and ID/EX register live in the top module.

## Test plan
- Reset, then VADD r3,r1,r2 with r1=5, r2=7 preloaded via WB → next cycle ID_EX_Valid=1, A=5, B=7, Stall=0.
- LOAD r4, then VADD r5,r4,r4 → Stall=1 and bubbles until WB_WrEn to r4 with data 9. The VADD issues in that WB cycle with A=B=9.
- WB writes r6=0xAA in the same cycle VOR reads r6 → ID_EX_A=0xAA.
- BEZ r7 with r7=0, imm=0x0040 → Branch_Taken=1 for one cycle, Branch_Target=0x40. The following IF_ID instruction is squashed (ID_EX_Valid=0).
- BNEZ r7 with r7=0 → Branch_Taken=0. The following instruction issues normally.
- Assert reset while stalled on a busy r4 → all outputs at reset values, scoreboard clear. A fresh VADD using r4 issues without stall.
